// File: rtl/ac97_pkg.sv
// Shared types and constants for the AC97 command scheduler.
// Holds the FSM state encoding, codec register indices and the power-up init table.
package ac97_pkg;

  typedef enum logic [1:0] {
    ST_INIT    = 2'd0,
    ST_IDLE    = 2'd1,
    ST_PEND    = 2'd2,
    ST_WAIT_RD = 2'd3
  } state_t;

  localparam logic [6:0] REG_MASTER_VOL = 7'h02;
  localparam logic [6:0] REG_HP_VOL     = 7'h04;
  localparam logic [6:0] REG_PCM_VOL    = 7'h18;
  localparam logic [6:0] REG_LINE_IN    = 7'h10;
  localparam logic [6:0] REG_REC_SEL    = 7'h1A;
  localparam logic [6:0] REG_REC_GAIN   = 7'h1C;

  localparam int CMD_READ_BIT = 7;
  localparam int INIT_ENTRIES = 6;
  localparam int INIT_IDX_W   = 3;

  // Entry 0 is the rightmost element; each entry is {cmd_addr, cmd_data}.
  localparam logic [INIT_ENTRIES-1:0][23:0] INIT_TABLE = {
    {1'b0, REG_REC_GAIN,   16'h0000},
    {1'b0, REG_REC_SEL,    16'h0000},
    {1'b0, REG_LINE_IN,    16'h0808},
    {1'b0, REG_PCM_VOL,    16'h0808},
    {1'b0, REG_HP_VOL,     16'h0808},
    {1'b0, REG_MASTER_VOL, 16'h0808}
  };

  // Same attenuation on both channels of the master volume register.
  function automatic logic [15:0] vol_cmd_data(input logic [4:0] lvl);
    return {3'b000, lvl, 3'b000, lvl};
  endfunction

endpackage

// File: rtl/ac97_init_rom.sv
// Combinational lookup of the codec initialisation table.
// Indices past the table length return an all-zero entry.
module ac97_init_rom
  import ac97_pkg::*;
#(
  parameter int INIT_LEN = 6
) (
  input  logic [INIT_IDX_W-1:0] i_idx,
  output logic [23:0]           o_entry
);

  always_comb begin
    o_entry = '0;
    if (int'(i_idx) < INIT_LEN) o_entry = INIT_TABLE[i_idx];
  end

endmodule

// File: rtl/ac97_cmd_scheduler.sv
// AC97 slot 1/2 command scheduler: codec init, host/volume arbitration and read matching.
// state      | meaning
// ST_INIT    | playing the init table, one entry per frame
// ST_IDLE    | waiting for a host or volume request
// ST_PEND    | command loaded, waiting for its issuing frame_start
// ST_WAIT_RD | host read issued, waiting for status match or timeout
module ac97_cmd_scheduler
  import ac97_pkg::*;
#(
  parameter int INIT_LEN     = 6,
  parameter int READ_TIMEOUT = 4
) (
  input  logic        clock,
  input  logic        reset_b,
  input  logic        frame_start,
  input  logic        host_req,
  input  logic        host_rw,
  input  logic [6:0]  host_addr,
  input  logic [15:0] host_wdata,
  output logic        host_ack,
  output logic [15:0] host_rdata,
  output logic        host_err,
  input  logic        vol_req,
  input  logic [4:0]  vol_level,
  output logic        vol_ack,
  input  logic        status_valid,
  input  logic [6:0]  status_addr,
  input  logic [15:0] status_data,
  output logic        cmd_valid,
  output logic [7:0]  cmd_addr,
  output logic [15:0] cmd_data,
  output logic        init_done
);

  localparam int TW = $clog2(READ_TIMEOUT + 1);

  state_t                r_state, w_state_next;
  logic [INIT_IDX_W-1:0] r_init_idx;
  logic [TW-1:0]         r_to_cnt;
  logic [TW-1:0]         w_to_next;
  logic                  r_rr_host;
  logic                  r_grant_vol;
  logic                  r_grant_rd;
  logic [23:0]           w_rom_entry;

  logic w_host_ok, w_vol_ok, w_pick_vol;
  logic w_init_load, w_init_issue, w_init_last;
  logic w_idle_load, w_pend_issue, w_rd_match, w_rd_timeout;

  logic        w_cmd_valid_d, w_host_ack_d, w_vol_ack_d, w_host_err_d;
  logic [7:0]  w_cmd_addr_d;
  logic [15:0] w_cmd_data_d, w_host_rdata_d;

  ac97_init_rom #(.INIT_LEN(INIT_LEN)) u_rom (
    .i_idx   (r_init_idx),
    .o_entry (w_rom_entry)
  );

  // A requester still holding req during its ack cycle must not be granted again.
  assign w_host_ok    = host_req & ~host_ack;
  assign w_vol_ok     = vol_req & ~vol_ack;
  assign w_pick_vol   = w_vol_ok & (~w_host_ok | ~r_rr_host);

  assign w_init_last  = (r_init_idx == INIT_IDX_W'(INIT_LEN - 1));
  assign w_init_load  = (r_state == ST_INIT) & ~frame_start & ~cmd_valid;
  assign w_init_issue = (r_state == ST_INIT) & frame_start & cmd_valid;
  assign w_idle_load  = (r_state == ST_IDLE) & ~frame_start & (w_host_ok | w_vol_ok);
  assign w_pend_issue = (r_state == ST_PEND) & frame_start;
  assign w_to_next    = r_to_cnt + TW'(1);
  assign w_rd_match   = (r_state == ST_WAIT_RD) & status_valid & (status_addr == host_addr);
  assign w_rd_timeout = (r_state == ST_WAIT_RD) & ~w_rd_match & frame_start &
                        (w_to_next == TW'(READ_TIMEOUT));

  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) r_state <= ST_INIT;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_INIT:    if (w_init_issue && w_init_last) w_state_next = ST_IDLE;
      ST_IDLE:    if (w_idle_load) w_state_next = ST_PEND;
      ST_PEND:    if (frame_start) w_state_next = r_grant_rd ? ST_WAIT_RD : ST_IDLE;
      ST_WAIT_RD: if (w_rd_match || w_rd_timeout) w_state_next = ST_IDLE;
      default:    w_state_next = ST_INIT;
    endcase
  end

  always_comb begin
    w_cmd_valid_d  = cmd_valid;
    w_cmd_addr_d   = cmd_addr;
    w_cmd_data_d   = cmd_data;
    w_host_ack_d   = 1'b0;
    w_vol_ack_d    = 1'b0;
    w_host_rdata_d = host_rdata;
    w_host_err_d   = host_err;
    if (w_init_load) begin
      w_cmd_valid_d = 1'b1;
      w_cmd_addr_d  = w_rom_entry[23:16];
      w_cmd_data_d  = w_rom_entry[15:0];
    end
    if (w_init_issue) w_cmd_valid_d = 1'b0;
    if (w_idle_load) begin
      w_cmd_valid_d = 1'b1;
      if (w_pick_vol) begin
        w_cmd_addr_d = {1'b0, REG_MASTER_VOL};
        w_cmd_data_d = vol_cmd_data(vol_level);
      end else begin
        w_cmd_addr_d               = {1'b0, host_addr};
        w_cmd_addr_d[CMD_READ_BIT] = host_rw;
        w_cmd_data_d               = host_rw ? 16'h0000 : host_wdata;
      end
    end
    if (w_pend_issue) begin
      w_cmd_valid_d = 1'b0;
      if (r_grant_vol) begin
        w_vol_ack_d = 1'b1;
      end else if (!r_grant_rd) begin
        w_host_ack_d = 1'b1;
        w_host_err_d = 1'b0;
      end
    end
    if (w_rd_match) begin
      w_host_ack_d   = 1'b1;
      w_host_rdata_d = status_data;
      w_host_err_d   = 1'b0;
    end else if (w_rd_timeout) begin
      w_host_ack_d   = 1'b1;
      w_host_rdata_d = 16'h0000;
      w_host_err_d   = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      cmd_valid   <= 1'b0;
      cmd_addr    <= '0;
      cmd_data    <= '0;
      host_ack    <= 1'b0;
      vol_ack     <= 1'b0;
      host_rdata  <= '0;
      host_err    <= 1'b0;
      init_done   <= 1'b0;
      r_init_idx  <= '0;
      r_to_cnt    <= '0;
      r_rr_host   <= 1'b1;
      r_grant_vol <= 1'b0;
      r_grant_rd  <= 1'b0;
    end else begin
      cmd_valid  <= w_cmd_valid_d;
      cmd_addr   <= w_cmd_addr_d;
      cmd_data   <= w_cmd_data_d;
      host_ack   <= w_host_ack_d;
      vol_ack    <= w_vol_ack_d;
      host_rdata <= w_host_rdata_d;
      host_err   <= w_host_err_d;
      if (w_init_issue) r_init_idx <= r_init_idx + INIT_IDX_W'(1);
      if (w_init_issue && w_init_last) init_done <= 1'b1;
      // Priority goes to whichever side lost this grant.
      if (w_idle_load) begin
        r_rr_host   <= w_pick_vol;
        r_grant_vol <= w_pick_vol;
        r_grant_rd  <= ~w_pick_vol & host_rw;
      end
      if (w_pend_issue) r_to_cnt <= '0;
      else if (r_state == ST_WAIT_RD && frame_start) r_to_cnt <= w_to_next;
    end
  end

endmodule

// File: tb/tb_ac97_cmd_scheduler.sv
// Self-checking bench for ac97_cmd_scheduler: issued commands are checked against a scoreboard queue.
module tb_ac97_cmd_scheduler;

  localparam int FRAME = 256;

  logic        clock = 1'b0;
  logic        reset_b = 1'b0;
  logic        frame_start = 1'b0;
  logic        host_req = 1'b0;
  logic        host_rw = 1'b0;
  logic [6:0]  host_addr = '0;
  logic [15:0] host_wdata = '0;
  logic        vol_req = 1'b0;
  logic [4:0]  vol_level = '0;
  logic        status_valid = 1'b0;
  logic [6:0]  status_addr = '0;
  logic [15:0] status_data = '0;
  logic        host_ack, host_err, vol_ack, cmd_valid, init_done;
  logic [15:0] host_rdata, cmd_data;
  logic [7:0]  cmd_addr;

  int n_checks = 0;
  int n_fail = 0;
  int n_issued = 0;
  int n_host_ack = 0;
  int n_vol_ack = 0;
  int cyc = 0;
  int last_issue_cyc = -10;
  int fcnt = 0;
  logic [23:0] exp_q[$];

  ac97_cmd_scheduler #(.INIT_LEN(6), .READ_TIMEOUT(4)) dut (
    .clock(clock), .reset_b(reset_b), .frame_start(frame_start),
    .host_req(host_req), .host_rw(host_rw), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_ack(host_ack), .host_rdata(host_rdata), .host_err(host_err),
    .vol_req(vol_req), .vol_level(vol_level), .vol_ack(vol_ack),
    .status_valid(status_valid), .status_addr(status_addr), .status_data(status_data),
    .cmd_valid(cmd_valid), .cmd_addr(cmd_addr), .cmd_data(cmd_data), .init_done(init_done)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc++;

  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (!reset_b) begin
        fcnt = 0;
        frame_start = 1'b0;
      end else begin
        frame_start = (fcnt == FRAME - 1);
        fcnt = (fcnt == FRAME - 1) ? 0 : fcnt + 1;
      end
    end
  end

  // Scoreboard: every issued command must be the next expected one.
  always @(negedge clock) begin
    if (reset_b && frame_start && cmd_valid) begin
      logic [23:0] e;
      n_issued++;
      last_issue_cyc = cyc;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL issue_unexpected: got %h, required no command", {cmd_addr, cmd_data});
      end else begin
        e = exp_q.pop_front();
        if ({cmd_addr, cmd_data} !== e) begin
          n_fail++;
          $display("FAIL issue_cmd: got %h, required %h", {cmd_addr, cmd_data}, e);
        end
      end
    end
    if (reset_b && host_ack) n_host_ack++;
    if (reset_b && vol_ack) n_vol_ack++;
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  task automatic wait_frame(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2 * FRAME && !ok; i++) begin
      @(posedge clock);
      #2;
      if (frame_start) ok = 1'b1;
    end
  endtask

  task automatic wait_issues(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(posedge clock);
      #2;
      if (n_issued >= target) ok = 1'b1;
    end
  endtask

  task automatic wait_ack(input bit vol, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clock);
      if (vol ? vol_ack : host_ack) ok = 1'b1;
    end
  endtask

  task automatic push_init();
    exp_q.push_back(24'h020808);
    exp_q.push_back(24'h040808);
    exp_q.push_back(24'h180808);
    exp_q.push_back(24'h100808);
    exp_q.push_back(24'h1A0000);
    exp_q.push_back(24'h1C0000);
  endtask

  task automatic test_reset();
    wait_cycles(3);
    n_checks++;
    if ({cmd_valid, cmd_addr, cmd_data, host_ack, host_rdata, host_err, vol_ack, init_done} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h, required 0",
               {cmd_valid, cmd_addr, cmd_data, host_ack, host_rdata, host_err, vol_ack, init_done});
    end
  endtask

  task automatic test_init(input string tag);
    bit ok;
    int base;
    base = n_issued;
    reset_b = 1'b1;
    wait_issues(base + 5, 7 * FRAME, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL %s_five_issues: got %0d issues, required 5", tag, n_issued - base); end
    n_checks++;
    if (init_done !== 1'b0) begin n_fail++; $display("FAIL %s_done_early: got %b, required 0", tag, init_done); end
    wait_issues(base + 6, 2 * FRAME, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL %s_six_issues: got %0d issues, required 6", tag, n_issued - base); end
    n_checks++;
    if (init_done !== 1'b1) begin n_fail++; $display("FAIL %s_done: got %b, required 1", tag, init_done); end
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL %s_queue_left: got %0d, required 0", tag, exp_q.size()); end
  endtask

  task automatic test_volume();
    bit ok;
    int base;
    wait_frame(ok);
    wait_cycles(3);
    base = n_vol_ack;
    exp_q.push_back(24'h020A0A);
    vol_level = 5'h0A;
    vol_req = 1'b1;
    @(negedge clock);
    @(negedge clock);
    n_checks++;
    if ({cmd_valid, cmd_addr, cmd_data} !== {1'b1, 8'h02, 16'h0A0A}) begin
      n_fail++;
      $display("FAIL vol_load_t1: got %h, required %h", {cmd_valid, cmd_addr, cmd_data}, {1'b1, 8'h02, 16'h0A0A});
    end
    wait_ack(1'b1, 2 * FRAME, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL vol_ack_seen: got none, required pulse"); end
    n_checks++;
    if (cyc !== last_issue_cyc + 1) begin n_fail++; $display("FAIL vol_ack_timing: got cycle %0d, required %0d", cyc, last_issue_cyc + 1); end
    @(posedge clock); #2;
    vol_req = 1'b0;
    wait_cycles(FRAME + 4);
    n_checks++;
    if (n_vol_ack !== base + 1) begin n_fail++; $display("FAIL vol_ack_once: got %0d, required 1", n_vol_ack - base); end
  endtask

  task automatic test_frame_edge_req();
    bit ok;
    wait_frame(ok);
    exp_q.push_back(24'h021111);
    vol_level = 5'h11;
    vol_req = 1'b1;
    @(negedge clock);
    @(negedge clock);
    n_checks++;
    if (cmd_valid !== 1'b0) begin n_fail++; $display("FAIL edge_no_load: got %b, required 0", cmd_valid); end
    @(negedge clock);
    n_checks++;
    if (cmd_valid !== 1'b1) begin n_fail++; $display("FAIL edge_late_load: got %b, required 1", cmd_valid); end
    wait_ack(1'b1, 2 * FRAME, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL edge_ack_seen: got none, required pulse"); end
    @(posedge clock); #2;
    vol_req = 1'b0;
  endtask

  task automatic test_contention();
    bit ok;
    int vb, hb;
    wait_cycles(3);
    exp_q.push_back(24'h181234);
    exp_q.push_back(24'h020303);
    vb = n_vol_ack;
    host_rw = 1'b0; host_addr = 7'h18; host_wdata = 16'h1234; host_req = 1'b1;
    vol_level = 5'h03; vol_req = 1'b1;
    wait_ack(1'b0, 2 * FRAME, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL cont1_host_ack: got none, required pulse"); end
    n_checks++;
    if (n_vol_ack !== vb) begin n_fail++; $display("FAIL cont1_order: got %0d vol acks, required 0", n_vol_ack - vb); end
    @(posedge clock); #2;
    host_req = 1'b0;
    wait_ack(1'b1, 2 * FRAME, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL cont1_vol_ack: got none, required pulse"); end
    @(posedge clock); #2;
    vol_req = 1'b0;

    wait_cycles(3);
    exp_q.push_back(24'h041111);
    host_addr = 7'h04; host_wdata = 16'h1111; host_req = 1'b1;
    wait_ack(1'b0, 2 * FRAME, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL solo_host_ack: got none, required pulse"); end
    @(posedge clock); #2;
    host_req = 1'b0;

    wait_cycles(3);
    exp_q.push_back(24'h021F1F);
    exp_q.push_back(24'h102222);
    hb = n_host_ack;
    host_addr = 7'h10; host_wdata = 16'h2222; host_req = 1'b1;
    vol_level = 5'h1F; vol_req = 1'b1;
    wait_ack(1'b1, 2 * FRAME, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL cont2_vol_ack: got none, required pulse"); end
    n_checks++;
    if (n_host_ack !== hb) begin n_fail++; $display("FAIL cont2_order: got %0d host acks, required 0", n_host_ack - hb); end
    @(posedge clock); #2;
    vol_req = 1'b0;
    wait_ack(1'b0, 2 * FRAME, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL cont2_host_ack: got none, required pulse"); end
    @(posedge clock); #2;
    host_req = 1'b0;
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL cont_queue_left: got %0d, required 0", exp_q.size()); end
  endtask

  task automatic test_host_read();
    bit ok;
    int base, hb;
    wait_cycles(3);
    exp_q.push_back(24'hFC0000);
    base = n_issued;
    host_rw = 1'b1; host_addr = 7'h7C; host_req = 1'b1;
    wait_issues(base + 1, 2 * FRAME, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL rd_issue: got none, required read command"); end
    hb = n_host_ack;
    wait_frame(ok);
    wait_cycles(5);
    status_valid = 1'b1; status_addr = 7'h10; status_data = 16'hDEAD;
    wait_cycles(1);
    status_valid = 1'b0;
    wait_cycles(2);
    n_checks++;
    if ({n_host_ack - hb, cmd_valid} !== {32'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL rd_wait_idle: got acks %0d cmd_valid %b, required 0 0", n_host_ack - hb, cmd_valid);
    end
    wait_frame(ok);
    wait_cycles(5);
    status_valid = 1'b1; status_addr = 7'h7C; status_data = 16'h4144;
    @(negedge clock);
    @(posedge clock); #2;
    status_valid = 1'b0;
    @(negedge clock);
    n_checks++;
    if ({host_ack, host_err, host_rdata} !== {1'b1, 1'b0, 16'h4144}) begin
      n_fail++;
      $display("FAIL rd_match: got ack %b err %b data %h, required 1 0 4144", host_ack, host_err, host_rdata);
    end
    @(posedge clock); #2;
    host_req = 1'b0;
    n_checks++;
    if (n_issued !== base + 1) begin n_fail++; $display("FAIL rd_no_extra_issue: got %0d, required 1", n_issued - base); end
  endtask

  task automatic test_read_coincident();
    bit ok;
    int base;
    wait_cycles(3);
    exp_q.push_back(24'hA00000);
    base = n_issued;
    host_rw = 1'b1; host_addr = 7'h20; host_req = 1'b1;
    wait_issues(base + 1, 2 * FRAME, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL co_issue: got none, required read command"); end
    repeat (4) wait_frame(ok);
    status_valid = 1'b1; status_addr = 7'h20; status_data = 16'hBEEF;
    @(negedge clock);
    @(posedge clock); #2;
    status_valid = 1'b0;
    @(negedge clock);
    n_checks++;
    if ({host_ack, host_err, host_rdata} !== {1'b1, 1'b0, 16'hBEEF}) begin
      n_fail++;
      $display("FAIL co_match_wins: got ack %b err %b data %h, required 1 0 beef", host_ack, host_err, host_rdata);
    end
    @(posedge clock); #2;
    host_req = 1'b0;
  endtask

  task automatic test_timeout();
    bit ok;
    int base, hb;
    wait_cycles(3);
    exp_q.push_back(24'hA60000);
    base = n_issued;
    host_rw = 1'b1; host_addr = 7'h26; host_req = 1'b1;
    wait_issues(base + 1, 2 * FRAME, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL to_issue: got none, required read command"); end
    hb = n_host_ack;
    repeat (3) wait_frame(ok);
    wait_cycles(2);
    n_checks++;
    if (n_host_ack !== hb) begin n_fail++; $display("FAIL to_early: got %0d acks after 3 frames, required 0", n_host_ack - hb); end
    wait_frame(ok);
    @(negedge clock);
    @(negedge clock);
    n_checks++;
    if ({host_ack, host_err, host_rdata} !== {1'b1, 1'b1, 16'h0000}) begin
      n_fail++;
      $display("FAIL to_ack: got ack %b err %b data %h, required 1 1 0000", host_ack, host_err, host_rdata);
    end
    @(posedge clock); #2;
    host_req = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit ok;
    int base;
    wait_cycles(3);
    exp_q.push_back(24'hB00000);
    base = n_issued;
    host_rw = 1'b1; host_addr = 7'h30; host_req = 1'b1;
    wait_issues(base + 1, 2 * FRAME, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL mid_issue: got none, required read command"); end
    wait_frame(ok);
    wait_cycles(10);
    @(posedge clock);
    #3;
    reset_b = 1'b0;
    #1;
    n_checks++;
    if ({cmd_valid, cmd_addr, cmd_data, host_ack, host_rdata, host_err, vol_ack, init_done} !== '0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: got %h, required 0",
               {cmd_valid, cmd_addr, cmd_data, host_ack, host_rdata, host_err, vol_ack, init_done});
    end
    host_req = 1'b0;
    host_rw = 1'b0;
    exp_q.delete();
    push_init();
    wait_cycles(5);
    test_init("reinit");
  endtask

  initial begin
    test_reset();
    push_init();
    test_init("init");
    test_volume();
    test_frame_edge_req();
    test_contention();
    test_host_read();
    test_read_coincident();
    test_timeout();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
